// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
// Memory request/response bus: the master modport issues requests and the
// slave modport returns the ready pulse and read data.
interface mem_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Round-robin two-master arbiter for the core memory bus with registered responses.
// Define MEM_ARBITER_TIMEOUT_EN to enable the slave-ready watchdog and error flag.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master slv,
    output logic          grant,
    output logic          timeout_err,
    output logic          err_master,
    input  logic          err_clear
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    logic   last_grant;
    logic   pick;

    // On contention the master that did not win last time goes next.
    assign pick = (m0.valid && m1.valid) ? ~last_grant : m1.valid;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_next;
    logic             wd_fire;

    // Fires in the TIMEOUT-th consecutive BUSY cycle without slv_ready.
    assign wd_next = wd_cnt + CNT_W'(1);
    assign wd_fire = (wd_next == CNT_W'(TIMEOUT));
`else
    logic unused_cfg;

    assign timeout_err = 1'b0;
    assign err_master  = 1'b0;
    assign unused_cfg  = err_clear ^ (TIMEOUT == 0) ^ ERR_DATA[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slv.valid  <= 1'b0;
            slv.addr   <= 32'h0;
            slv.wdata  <= 32'h0;
            slv.wstrb  <= 4'h0;
            m0.ready   <= 1'b0;
            m1.ready   <= 1'b0;
            m0.rdata   <= 32'h0;
            m1.rdata   <= 32'h0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
`ifdef MEM_ARBITER_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            err_master  <= 1'b0;
`endif
        end else begin
            m0.ready <= 1'b0;
            m1.ready <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            // A timeout raised later in this block overrides the clear.
            if (err_clear) begin
                timeout_err <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (m0.valid || m1.valid) begin
                        slv.valid  <= 1'b1;
                        slv.addr   <= pick ? m1.addr  : m0.addr;
                        slv.wdata  <= pick ? m1.wdata : m0.wdata;
                        slv.wstrb  <= pick ? m1.wstrb : m0.wstrb;
                        grant      <= pick;
                        last_grant <= pick;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (slv.ready) begin
                        slv.valid <= 1'b0;
                        state     <= RESP;
                        if (grant) begin
                            m1.rdata <= slv.rdata;
                            m1.ready <= 1'b1;
                        end else begin
                            m0.rdata <= slv.rdata;
                            m0.ready <= 1'b1;
                        end
                    end
`ifdef MEM_ARBITER_TIMEOUT_EN
                    else if (wd_fire) begin
                        slv.valid   <= 1'b0;
                        state       <= RESP;
                        timeout_err <= 1'b1;
                        err_master  <= grant;
                        if (grant) begin
                            m1.rdata <= ERR_DATA;
                            m1.ready <= 1'b1;
                        end else begin
                            m0.rdata <= ERR_DATA;
                            m0.ready <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_next;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter: directed vectors, corner-case sequences
// and randomized traffic compared against a transaction-level model.
module tb_mem_arbiter;
    localparam int unsigned TO = 4;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int WRITE_WAITS = 2;
`else
    localparam int WRITE_WAITS = 5;
`endif

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] data;
        logic        exp_grant;
        logic [31:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic grant, timeout_err, err_master;
    logic err_clear = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    mem_arbiter_if m0_bus();
    mem_arbiter_if m1_bus();
    mem_arbiter_if slv_bus();

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'h0)) dut (
        .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .slv(slv_bus),
        .grant(grant), .timeout_err(timeout_err), .err_master(err_master),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    function automatic req_t mkReq(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.valid = v;
        r.addr  = a;
        r.wdata = d;
        r.wstrb = s;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input req_t r0, input req_t r1, input logic sr, input logic [31:0] srd);
        m0_bus.valid  = r0.valid;
        m0_bus.addr   = r0.addr;
        m0_bus.wdata  = r0.wdata;
        m0_bus.wstrb  = r0.wstrb;
        m1_bus.valid  = r1.valid;
        m1_bus.addr   = r1.addr;
        m1_bus.wdata  = r1.wdata;
        m1_bus.wstrb  = r1.wstrb;
        slv_bus.ready = sr;
        slv_bus.rdata = srd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutputBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        err_clear = 1'b0;
        applyStimulus(mkReq(1'b0, 32'h0, 32'h0, 4'h0), mkReq(1'b0, 32'h0, 32'h0, 4'h0), 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutputBit({tag, " slv_valid"}, slv_bus.valid, 1'b0);
        checkOutput({tag, " slv_addr"}, slv_bus.addr, 32'h0);
        checkOutput({tag, " slv_wdata"}, slv_bus.wdata, 32'h0);
        checkOutput({tag, " slv_wstrb"}, {28'h0, slv_bus.wstrb}, 32'h0);
        checkOutputBit({tag, " m0_ready"}, m0_bus.ready, 1'b0);
        checkOutputBit({tag, " m1_ready"}, m1_bus.ready, 1'b0);
        checkOutput({tag, " m0_rdata"}, m0_bus.rdata, 32'h0);
        checkOutput({tag, " m1_rdata"}, m1_bus.rdata, 32'h0);
        checkOutputBit({tag, " grant"}, grant, 1'b0);
        checkOutputBit({tag, " timeout_err"}, timeout_err, 1'b0);
        checkOutputBit({tag, " err_master"}, err_master, 1'b0);
    endtask

    // One zero-wait transaction for a lone master, starting from IDLE.
    task automatic runTxn(input logic m, input logic [31:0] data, input string tag);
        req_t r;
        r = mkReq(1'b1, 32'h0000_0F00, 32'h0, 4'h0);
        applyStimulus(m ? mkReq(1'b0, 32'h0, 32'h0, 4'h0) : r, m ? r : mkReq(1'b0, 32'h0, 32'h0, 4'h0), 1'b0, 32'h0);
        tick();
        checkOutputBit({tag, " grant"}, grant, m);
        applyStimulus(m ? mkReq(1'b0, 32'h0, 32'h0, 4'h0) : r, m ? r : mkReq(1'b0, 32'h0, 32'h0, 4'h0), 1'b1, data);
        tick();
        checkOutputBit({tag, " ready"}, m ? m1_bus.ready : m0_bus.ready, 1'b1);
        checkOutput({tag, " rdata"}, m ? m1_bus.rdata : m0_bus.rdata, data);
        applyStimulus(mkReq(1'b0, 32'h0, 32'h0, 4'h0), mkReq(1'b0, 32'h0, 32'h0, 4'h0), 1'b0, 32'h0);
        tick();
    endtask

    initial begin
        vec_t        vecs[8];
        req_t        none;
        req_t        pend[2];
        req_t        ra;
        req_t        rb;
        logic [31:0] held[2];
        logic        last;
        logic        w;
        int          lat;
        logic [31:0] d;

        none = mkReq(1'b0, 32'h0, 32'h0, 4'h0);
        vecs[0] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 4'h0, 0, 32'h1111_1111, 1'b0, 32'h0000_1000};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0000_2004, 4'hF, 1, 32'h2222_2222, 1'b1, 32'h0000_2004};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0000_2008, 4'h1, 0, 32'h3333_3333, 1'b0, 32'h0000_1008};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0000_200C, 4'h0, 2, 32'h4444_4444, 1'b0, 32'h0000_100C};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_1010, 32'h0000_2010, 4'h8, 0, 32'h5555_5555, 1'b1, 32'h0000_2010};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_1014, 32'h0000_2014, 4'h0, 1, 32'h6666_6666, 1'b0, 32'h0000_1014};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_1018, 32'h0000_2018, 4'h0, 0, 32'h7777_7777, 1'b1, 32'h0000_2018};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_101C, 32'h0000_201C, 4'h6, 2, 32'h8888_8888, 1'b0, 32'h0000_101C};

        doReset();
        checkResetValues("reset");

        // Minimum-latency read by master 0.
        ra = mkReq(1'b1, 32'h4000_0010, 32'h0, 4'h0);
        applyStimulus(ra, none, 1'b0, 32'h0);
        tick();
        checkOutputBit("single slv_valid c1", slv_bus.valid, 1'b1);
        checkOutput("single slv_addr c1", slv_bus.addr, 32'h4000_0010);
        checkOutputBit("single m0_ready c1", m0_bus.ready, 1'b0);
        applyStimulus(ra, none, 1'b1, 32'hDEAD_BEEF);
        tick();
        checkOutputBit("single m0_ready c2", m0_bus.ready, 1'b1);
        checkOutput("single m0_rdata c2", m0_bus.rdata, 32'hDEAD_BEEF);
        checkOutputBit("single m1_ready c2", m1_bus.ready, 1'b0);
        checkOutputBit("single slv_valid c2", slv_bus.valid, 1'b0);
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();
        checkOutputBit("single m0_ready c3", m0_bus.ready, 1'b0);
        checkOutput("single m0_rdata held", m0_bus.rdata, 32'hDEAD_BEEF);

        // Directed vector table.
        doReset();
        for (int i = 0; i < 8; i++) begin
            ra = mkReq(vecs[i].v0, vecs[i].a0, ~vecs[i].a0, vecs[i].wstrb);
            rb = mkReq(vecs[i].v1, vecs[i].a1, ~vecs[i].a1, vecs[i].wstrb);
            applyStimulus(ra, rb, 1'b0, 32'h0);
            tick();
            checkOutputBit($sformatf("vec%0d slv_valid", i), slv_bus.valid, 1'b1);
            checkOutputBit($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
            checkOutput($sformatf("vec%0d slv_addr", i), slv_bus.addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d slv_wdata", i), slv_bus.wdata, ~vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d slv_wstrb", i), {28'h0, slv_bus.wstrb}, {28'h0, vecs[i].wstrb});
            for (int k = 0; k < vecs[i].waits; k++) begin
                applyStimulus(ra, rb, 1'b0, 32'h0);
                tick();
                checkOutputBit($sformatf("vec%0d wait%0d slv_valid", i, k), slv_bus.valid, 1'b1);
                checkOutput($sformatf("vec%0d wait%0d slv_addr", i, k), slv_bus.addr, vecs[i].exp_addr);
            end
            applyStimulus(ra, rb, 1'b1, vecs[i].data);
            tick();
            checkOutputBit($sformatf("vec%0d winner ready", i), vecs[i].exp_grant ? m1_bus.ready : m0_bus.ready, 1'b1);
            checkOutputBit($sformatf("vec%0d loser ready", i), vecs[i].exp_grant ? m0_bus.ready : m1_bus.ready, 1'b0);
            checkOutput($sformatf("vec%0d rdata", i), vecs[i].exp_grant ? m1_bus.rdata : m0_bus.rdata, vecs[i].data);
            applyStimulus(none, none, 1'b0, 32'h0);
            tick();
            checkOutputBit($sformatf("vec%0d gap slv_valid", i), slv_bus.valid, 1'b0);
        end

        // Continuous contention from reset: grants alternate starting with master 0.
        doReset();
        ra = mkReq(1'b1, 32'h0000_A000, 32'h0, 4'h0);
        rb = mkReq(1'b1, 32'h0000_B000, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(ra, rb, 1'b0, 32'h0);
            tick();
            checkOutputBit($sformatf("alt%0d grant", i), grant, 1'(i % 2));
            applyStimulus(ra, rb, 1'b1, 32'hC000_0000 + 32'(i));
            tick();
            checkOutputBit($sformatf("alt%0d ready", i), (i % 2 == 1) ? m1_bus.ready : m0_bus.ready, 1'b1);
            checkOutputBit($sformatf("alt%0d other ready", i), (i % 2 == 1) ? m0_bus.ready : m1_bus.ready, 1'b0);
            applyStimulus(ra, rb, 1'b0, 32'h0);
            tick();
            checkOutputBit($sformatf("alt%0d gap", i), slv_bus.valid, 1'b0);
        end
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();
        tick();

        // Write by master 1 with slave wait states, then the mandatory gap.
        rb = mkReq(1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'h3);
        applyStimulus(none, rb, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < WRITE_WAITS; k++) begin
            checkOutputBit($sformatf("wr wait%0d slv_valid", k), slv_bus.valid, 1'b1);
            checkOutput($sformatf("wr wait%0d slv_wstrb", k), {28'h0, slv_bus.wstrb}, 32'h3);
            checkOutput($sformatf("wr wait%0d slv_wdata", k), slv_bus.wdata, 32'hCAFE_F00D);
            checkOutputBit($sformatf("wr wait%0d m1_ready", k), m1_bus.ready, 1'b0);
            applyStimulus(none, rb, 1'b0, 32'h0);
            tick();
        end
        checkOutput("wr slv_wdata last", slv_bus.wdata, 32'hCAFE_F00D);
        applyStimulus(none, rb, 1'b1, 32'h0BAD_CAFE);
        tick();
        checkOutputBit("wr m1_ready", m1_bus.ready, 1'b1);
        checkOutput("wr m1_rdata", m1_bus.rdata, 32'h0BAD_CAFE);
        checkOutputBit("wr m0_ready", m0_bus.ready, 1'b0);
        applyStimulus(none, rb, 1'b0, 32'h0);
        tick();
        checkOutputBit("wr gap slv_valid", slv_bus.valid, 1'b0);
        checkOutputBit("wr gap m1_ready", m1_bus.ready, 1'b0);
        tick();
        checkOutputBit("wr next slv_valid", slv_bus.valid, 1'b1);
        applyStimulus(none, rb, 1'b1, 32'h0);
        tick();
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();

        // Randomized traffic against a transaction-level model.
        doReset();
        last    = 1'b1;
        held[0] = 32'h0;
        held[1] = 32'h0;
        pend[0] = none;
        pend[1] = none;
        for (int r = 0; r < 60; r++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m].valid && $urandom_range(0, 2) != 0) begin
                    pend[m] = mkReq(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            if (!pend[0].valid && !pend[1].valid) begin
                applyStimulus(pend[0], pend[1], 1'($urandom_range(0, 1)), $urandom);
                tick();
                checkOutputBit($sformatf("rnd%0d idle slv_valid", r), slv_bus.valid, 1'b0);
                continue;
            end
            w   = (pend[0].valid && pend[1].valid) ? ~last : pend[1].valid;
            lat = $urandom_range(0, 2);
            d   = $urandom;
            applyStimulus(pend[0], pend[1], 1'($urandom_range(0, 1)), $urandom);
            tick();
            checkOutputBit($sformatf("rnd%0d slv_valid", r), slv_bus.valid, 1'b1);
            checkOutputBit($sformatf("rnd%0d grant", r), grant, w);
            checkOutput($sformatf("rnd%0d slv_addr", r), slv_bus.addr, pend[w].addr);
            checkOutput($sformatf("rnd%0d slv_wdata", r), slv_bus.wdata, pend[w].wdata);
            checkOutput($sformatf("rnd%0d slv_wstrb", r), {28'h0, slv_bus.wstrb}, {28'h0, pend[w].wstrb});
            for (int k = 0; k < lat; k++) begin
                applyStimulus(pend[0], pend[1], 1'b0, $urandom);
                tick();
                checkOutputBit($sformatf("rnd%0d wait slv_valid", r), slv_bus.valid, 1'b1);
                checkOutput($sformatf("rnd%0d wait slv_addr", r), slv_bus.addr, pend[w].addr);
            end
            applyStimulus(pend[0], pend[1], 1'b1, d);
            tick();
            checkOutputBit($sformatf("rnd%0d winner ready", r), w ? m1_bus.ready : m0_bus.ready, 1'b1);
            checkOutputBit($sformatf("rnd%0d loser ready", r), w ? m0_bus.ready : m1_bus.ready, 1'b0);
            checkOutput($sformatf("rnd%0d winner rdata", r), w ? m1_bus.rdata : m0_bus.rdata, d);
            checkOutput($sformatf("rnd%0d loser rdata", r), w ? m0_bus.rdata : m1_bus.rdata, held[~w]);
            checkOutputBit($sformatf("rnd%0d resp slv_valid", r), slv_bus.valid, 1'b0);
            held[w]       = d;
            last          = w;
            pend[w].valid = 1'b0;
            applyStimulus(pend[0], pend[1], 1'($urandom_range(0, 1)), $urandom);
            tick();
            checkOutputBit($sformatf("rnd%0d gap m0_ready", r), m0_bus.ready, 1'b0);
            checkOutputBit($sformatf("rnd%0d gap m1_ready", r), m1_bus.ready, 1'b0);
            checkOutputBit($sformatf("rnd%0d gap slv_valid", r), slv_bus.valid, 1'b0);
        end
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Watchdog: slave never answers master 0.
        doReset();
        runTxn(1'b0, 32'h1234_5678, "wd pre");
        ra = mkReq(1'b1, 32'h5000_0000, 32'h0, 4'h0);
        applyStimulus(ra, none, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < int'(TO); k++) begin
            checkOutputBit($sformatf("wd0 c%0d slv_valid", k), slv_bus.valid, 1'b1);
            checkOutputBit($sformatf("wd0 c%0d m0_ready", k), m0_bus.ready, 1'b0);
            applyStimulus(ra, none, 1'b0, 32'h0);
            tick();
        end
        checkOutputBit("wd0 m0_ready", m0_bus.ready, 1'b1);
        checkOutput("wd0 m0_rdata", m0_bus.rdata, 32'h0);
        checkOutputBit("wd0 timeout_err", timeout_err, 1'b1);
        checkOutputBit("wd0 err_master", err_master, 1'b0);
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();
        tick();
        checkOutputBit("wd0 sticky", timeout_err, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checkOutputBit("wd0 cleared", timeout_err, 1'b0);

        // Master 1 timeout while err_clear is held: the new error wins.
        rb = mkReq(1'b1, 32'h5000_0004, 32'h0, 4'h0);
        err_clear = 1'b1;
        applyStimulus(none, rb, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < int'(TO); k++) begin
            applyStimulus(none, rb, 1'b0, 32'h0);
            tick();
        end
        err_clear = 1'b0;
        checkOutputBit("wd1 m1_ready", m1_bus.ready, 1'b1);
        checkOutputBit("wd1 set wins", timeout_err, 1'b1);
        checkOutputBit("wd1 err_master", err_master, 1'b1);
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();
        checkOutputBit("wd1 sticky", timeout_err, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checkOutputBit("wd1 cleared", timeout_err, 1'b0);

        // slv_ready in the same cycle as the limit returns real data.
        applyStimulus(ra, none, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < int'(TO) - 1; k++) begin
            applyStimulus(ra, none, 1'b0, 32'h0);
            tick();
        end
        checkOutputBit("wdc slv_valid last", slv_bus.valid, 1'b1);
        applyStimulus(ra, none, 1'b1, 32'hA5A5_A5A5);
        tick();
        checkOutputBit("wdc m0_ready", m0_bus.ready, 1'b1);
        checkOutput("wdc m0_rdata", m0_bus.rdata, 32'hA5A5_A5A5);
        checkOutputBit("wdc timeout_err", timeout_err, 1'b0);
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();
`else
        // Without the watchdog a silent slave stalls the bus indefinitely.
        begin
            int hi;
            int pulses;
            hi     = 0;
            pulses = 0;
            ra = mkReq(1'b1, 32'h5000_0000, 32'h0, 4'h0);
            applyStimulus(ra, none, 1'b0, 32'h0);
            tick();
            for (int k = 0; k < 1100; k++) begin
                if (slv_bus.valid === 1'b1) hi++;
                if (m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0) pulses++;
                applyStimulus(ra, none, 1'b0, 32'h0);
                tick();
            end
            checkOutput("nowd slv_valid cycles", 32'(hi), 32'd1100);
            checkOutput("nowd ready pulses", 32'(pulses), 32'd0);
            checkOutputBit("nowd timeout_err", timeout_err, 1'b0);
            checkOutputBit("nowd err_master", err_master, 1'b0);
            doReset();
            checkOutputBit("nowd after reset slv_valid", slv_bus.valid, 1'b0);
        end
`endif

        // Reset in the middle of a master 1 transaction.
        runTxn(1'b1, 32'h7E57_0001, "rst pre");
        rb = mkReq(1'b1, 32'h6000_0000, 32'h1, 4'hF);
        applyStimulus(none, rb, 1'b0, 32'h0);
        tick();
        checkOutputBit("rst busy grant", grant, 1'b1);
        checkOutputBit("rst busy slv_valid", slv_bus.valid, 1'b1);
        rst = 1'b1;
        applyStimulus(none, rb, 1'b1, 32'hFFFF_FFFF);
        tick();
        checkOutputBit("rst edge slv_valid", slv_bus.valid, 1'b0);
        checkOutputBit("rst edge m1_ready", m1_bus.ready, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(none, none, 1'b1, 32'hFFFF_FFFF);
        tick();
        checkResetValues("rst after");
        ra = mkReq(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        rb = mkReq(1'b1, 32'h0000_0200, 32'h0, 4'h0);
        applyStimulus(ra, rb, 1'b0, 32'h0);
        tick();
        checkOutputBit("rst contention grant", grant, 1'b0);
        applyStimulus(ra, rb, 1'b1, 32'h0000_0042);
        tick();
        checkOutputBit("rst contention m0_ready", m0_bus.ready, 1'b1);
        applyStimulus(none, none, 1'b0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single core memory bus between the picorv32 CPU (master 0) and a secondary bus master such as a DMA or loader engine (master 1). It sits between the masters and the top-level address decoder/`muxed_*` response path. It grants the bus round-robin, holds the grant for one complete transaction, and registers the response back to the granted master. An optional watchdog terminates transactions to slaves that never assert ready.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles `slv_valid` may stay high without `slv_ready` before the watchdog fires. Legal range 1..65535.
- `ERR_DATA`, default 32'h0: read data returned on a watchdog-terminated transaction. 32'h0 is the illegal instruction, so a timed-out fetch traps.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high. The block has one clock, and reset is synchronous and active-high.
- `m0_valid`, `m1_valid` in 1 each: request. The master holds the request and its addr/wdata/wstrb stable until its ready pulse.
- `m0_addr`, `m1_addr` in 32 each: byte address.
- `m0_wdata`, `m1_wdata` in 32 each: write data.
- `m0_wstrb`, `m1_wstrb` in 4 each: byte write strobes. 4'h0 means read.
- `m0_ready`, `m1_ready` out 1 each: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out 32 each: read data. Valid during the ready pulse and held until the next completion.
- `slv_valid` out 1: request to the decoder.
- `slv_addr` out 32, `slv_wdata` out 32, `slv_wstrb` out 4: latched request of the granted master.
- `slv_rdata` in 32, `slv_ready` in 1: decoder response, sampled in the cycle `slv_ready`=1.
- `grant` out 1: id of the current or last granted master.
- `timeout_err` out 1: sticky watchdog flag.
- `err_master` out 1: id of the master whose transaction timed out.
- `err_clear` in 1: clears `timeout_err`.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:**
  - With no valid request, the block stays in IDLE.
  - With exactly one master valid, that master is granted.
  - With both masters valid, the master not equal to `last_grant` is granted.
  - On a grant, the block latches that master's addr/wdata/wstrb into `slv_*`, sets `grant`, updates `last_grant`, and clears the watchdog counter. It then moves to BUSY.
- **BUSY:**
  - `slv_valid`=1.
  - On `slv_ready`=1, the block captures `slv_rdata` into the granted master's rdata register, pulses that master's ready next cycle, and moves to RESP.
  - `slv_addr`/`slv_wdata`/`slv_wstrb` stay constant throughout BUSY.
- **RESP:**
  - `slv_valid`=0 and the granted `mN_ready`=1 for exactly this cycle.
  - The next state is always IDLE. This gives a mandatory gap cycle so the master can drop or change `valid`.
- **Non-granted master:** its `valid` is ignored while BUSY or RESP. Its ready stays 0 and its rdata is unchanged.
- **Write completion:** writes also complete with a ready pulse. The rdata register is still loaded with `slv_rdata`.
- **Fairness:** under continuous requests from both masters, grants strictly alternate 0,1,0,1…
- **Reset values:**
  - state=IDLE.
  - `slv_valid`=0, `slv_addr`=0, `slv_wdata`=0, `slv_wstrb`=0.
  - `m0_ready`=`m1_ready`=0, `m0_rdata`=`m1_rdata`=0.
  - `grant`=0, `last_grant`=1, so master 0 wins the first contention.
  - `timeout_err`=0, `err_master`=0.
- **Reset mid-transaction:** the transaction is abandoned and no ready pulse is issued. `slv_valid` is 0 from the cycle after the reset edge. A `slv_ready` arriving during or after reset is ignored.

## Timing
- **Minimum latency:**
  - Cycle 0: request sampled.
  - Cycle 1: `slv_valid`=1. If `slv_ready`=1 in cycle 1, the master ready pulses in cycle 2.
  - Total: `valid`-to-`ready` of 2 cycles plus the slave wait states.
- **Throughput:** back-to-back requests from the same master give at most one transaction per 3 cycles.
- **`slv_ready`:** sampled only in BUSY. A value of 1 in any other state is ignored.
- **Watchdog:**
  - The counter increments each BUSY cycle. Its width is ceil(log2(`TIMEOUT`+1)) and it does not wrap.
  - When it reaches `TIMEOUT` without `slv_ready`, the block loads `ERR_DATA` into the granted rdata, moves to RESP, sets `timeout_err`, and sets `err_master`=`grant`.
  - If `slv_ready` and the timeout coincide in the same cycle, `slv_ready` wins: real data is returned and no error is flagged.
- **Error flag:** `timeout_err` stays set until `err_clear`. If `err_clear` and a new timeout coincide, set wins.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN`: defined means the watchdog, `timeout_err` and `err_master` are active as above.
- Not defined means there is no counter: BUSY waits indefinitely for `slv_ready`, and `timeout_err`/`err_master` are tied to 0. The ports and parameters remain.

## Test plan
- **Single master 0 read:** `m0_addr`=32'h4000_0010, wstrb=0; slave answers 32'hDEADBEEF with ready in the first BUSY cycle -> `slv_valid` in cycle 1, `m0_ready` pulse in cycle 2 with `m0_rdata`=32'hDEADBEEF, `m1_ready` stays 0.
- **Contention from reset:** both valid in cycle 0 -> master 0 granted first, master 1 second. Both held continuously -> grants alternate 0,1,0,1 over 8 transactions.
- **Write with wait states:** `m1_wstrb`=4'h3, slave ready after 5 cycles -> `slv_wstrb`/`slv_wdata` stable for all 5 cycles, `m1_ready` pulse one cycle later, then one IDLE gap.
- **Watchdog (macro defined, `TIMEOUT`=4):** slave never ready -> `m0_ready` with `m0_rdata`=32'h0, `timeout_err`=1, `err_master`=0. Then `err_clear` -> `timeout_err`=0. A same-cycle `slv_ready` at the count limit returns slave data with no error.
- **Watchdog (macro undefined):** same stimulus -> `slv_valid` held for more than 1000 cycles, no ready pulse, `timeout_err`=0.
- **Reset mid-BUSY:** assert `rst` during BUSY, then `slv_ready`=1 -> no ready pulses, all outputs at reset values, and the next contention grants master 0.
